// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- memory pipeline stage of a simple in-order RISC core.
//
// Takes one instruction per idle cycle from EX. Non-memory instructions are
// registered straight through to the EX/MEM result (1-cycle latency). Loads
// and stores launch a single data-bus transaction and hold the front of the
// pipe (stallreq) until the bus returns dmem_ack. Load data is lane-selected
// and sign/zero extended before it is written to the stage result.
//
// Optional feature macro: MEM_MISALIGN_CHECK_EN
//   defined   : misaligned LH/LHU/SH/LW/SW are dropped, misalign pulses.
//   undefined : misalign tied 0, offending low address bits are ignored.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   ex_valid                   EX presents an instruction
//   ex_rd, ex_regwe            destination register / write enable
//   ex_result                  ALU result (wb data or byte address)
//   ex_memop                   0 none,1 LB,2 LH,3 LW,4 LBU,5 LHU,6 SB,7 SH,8 SW
//   ex_storedata               store source operand
//   dmem_req, dmem_we          bus request / write flag (held while busy)
//   dmem_addr, dmem_wdata      word address / replicated write data
//   dmem_be                    byte enables
//   dmem_ack, dmem_rdata       completion strobe / read word
//   ex_mem_rd, ex_mem_regwe    registered stage result to WB and forwarding
//   ex_mem_wbdata
//   stallreq                   hold EX and earlier stages (high while busy)
//   misalign                   one-cycle pulse for a dropped access
// ---------------------------------------------------------------------------
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwe,
  input  logic [31:0] ex_result,
  input  logic [3:0]  ex_memop,
  input  logic [31:0] ex_storedata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_regwe,
  output logic [31:0] ex_mem_wbdata,
  output logic        stallreq,
  output logic        misalign
);

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // -------------------------------------------------------------------------
  // EX memop decode
  // -------------------------------------------------------------------------
  logic  dec_load, dec_store, dec_uns, dec_mem;
  size_t dec_size;

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_uns   = 1'b0;
    dec_size  = SZ_W;
    case (ex_memop)
      OP_LB:  begin dec_load = 1'b1;  dec_size = SZ_B; end
      OP_LH:  begin dec_load = 1'b1;  dec_size = SZ_H; end
      OP_LW:  begin dec_load = 1'b1;  dec_size = SZ_W; end
      OP_LBU: begin dec_load = 1'b1;  dec_size = SZ_B; dec_uns = 1'b1; end
      OP_LHU: begin dec_load = 1'b1;  dec_size = SZ_H; dec_uns = 1'b1; end
      OP_SB:  begin dec_store = 1'b1; dec_size = SZ_B; end
      OP_SH:  begin dec_store = 1'b1; dec_size = SZ_H; end
      OP_SW:  begin dec_store = 1'b1; dec_size = SZ_W; end
      default: ;  // 0 and 9-15 behave as non-memory instructions
    endcase
  end

  assign dec_mem = dec_load | dec_store;

  logic misal_hit;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misal_hit = dec_mem &&
                     ((dec_size == SZ_H && ex_result[0]) ||
                      (dec_size == SZ_W && ex_result[1:0] != 2'b00));
`else
  assign misal_hit = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Lane helpers
  // -------------------------------------------------------------------------
  // Halfword lane comes from addr[1] alone, so an odd halfword address (when
  // not trapped) simply lands on the containing aligned half.
  function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the operand across every lane lets the memory pick the
  // lane purely from the byte enables.
  function automatic logic [31:0] store_data(input size_t sz, input logic [31:0] sd);
    case (sz)
      SZ_B:    return {4{sd[7:0]}};
      SZ_H:    return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] w, input size_t sz,
                                               input logic uns, input logic [1:0] off);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = w >> {off, 3'b000};
    b  = sh[7:0];
    h  = off[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_B:    return uns ? {24'h0, b} : {{24{b[7]}}, b};
      SZ_H:    return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // State and registered outputs
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [4:0]  rd_q, rd_d;
  logic        regwe_q, regwe_d;
  logic [31:0] wb_q, wb_d;

  // Attributes of the in-flight access needed when the ack arrives.
  logic [4:0]  cap_rd_q, cap_rd_d;
  logic        cap_regwe_q, cap_regwe_d;
  logic        cap_load_q, cap_load_d;
  logic        cap_uns_q, cap_uns_d;
  size_t       cap_size_q, cap_size_d;
  logic [1:0]  cap_off_q, cap_off_d;

`ifdef MEM_MISALIGN_CHECK_EN
  logic        misal_q, misal_d;
`endif

  always_comb begin
    // Everything holds unless a transition below says otherwise; this is
    // what keeps the bus outputs stable across a multi-cycle access.
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rd_d        = rd_q;
    regwe_d     = regwe_q;
    wb_d        = wb_q;
    cap_rd_d    = cap_rd_q;
    cap_regwe_d = cap_regwe_q;
    cap_load_d  = cap_load_q;
    cap_uns_d   = cap_uns_q;
    cap_size_d  = cap_size_q;
    cap_off_d   = cap_off_q;
`ifdef MEM_MISALIGN_CHECK_EN
    misal_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (!ex_valid) begin
          regwe_d = 1'b0;
        end else if (!dec_mem) begin
          rd_d    = ex_rd;
          regwe_d = ex_regwe;
          wb_d    = ex_result;
        end else if (misal_hit) begin
          regwe_d = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
          misal_d = 1'b1;
`endif
        end else begin
          state_d     = BUSY;
          req_d       = 1'b1;
          we_d        = dec_store;
          addr_d      = {ex_result[31:2], 2'b00};
          be_d        = dec_store ? store_be(dec_size, ex_result[1:0]) : 4'b1111;
          wdata_d     = dec_store ? store_data(dec_size, ex_storedata) : 32'h0;
          regwe_d     = 1'b0;
          cap_rd_d    = ex_rd;
          // A load to x0 still goes out on the bus but never writes back.
          cap_regwe_d = ex_regwe && (ex_rd != 5'd0);
          cap_load_d  = dec_load;
          cap_uns_d   = dec_uns;
          cap_size_d  = dec_size;
          cap_off_d   = ex_result[1:0];
        end
      end

      BUSY: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          if (cap_load_q) begin
            rd_d    = cap_rd_q;
            regwe_d = cap_regwe_q;
            wb_d    = load_extract(dmem_rdata, cap_size_q, cap_uns_q, cap_off_q);
          end else begin
            regwe_d = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      be_q        <= 4'h0;
      rd_q        <= 5'h0;
      regwe_q     <= 1'b0;
      wb_q        <= 32'h0;
      cap_rd_q    <= 5'h0;
      cap_regwe_q <= 1'b0;
      cap_load_q  <= 1'b0;
      cap_uns_q   <= 1'b0;
      cap_size_q  <= SZ_B;
      cap_off_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_q        <= rd_d;
      regwe_q     <= regwe_d;
      wb_q        <= wb_d;
      cap_rd_q    <= cap_rd_d;
      cap_regwe_q <= cap_regwe_d;
      cap_load_q  <= cap_load_d;
      cap_uns_q   <= cap_uns_d;
      cap_size_q  <= cap_size_d;
      cap_off_q   <= cap_off_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misal_q <= 1'b0;
    else        misal_q <= misal_d;
  end
  assign misalign = misal_q;
`else
  assign misalign = 1'b0;
`endif

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign ex_mem_rd     = rd_q;
  assign ex_mem_regwe  = regwe_q;
  assign ex_mem_wbdata = wb_q;
  // Includes the ack cycle: the next instruction is taken only once IDLE.
  assign stallreq      = (state_q == BUSY);

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver pushes expected bus requests,
// writebacks and misalign pulses computed by a byte-level memory model; a
// monitor pops and compares whenever the DUT presents them.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwe;
  logic [31:0] ex_result;
  logic [3:0]  ex_memop;
  logic [31:0] ex_storedata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [4:0]  ex_mem_rd;
  logic        ex_mem_regwe;
  logic [31:0] ex_mem_wbdata;
  logic        stallreq, misalign;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwe(ex_regwe),
    .ex_result(ex_result), .ex_memop(ex_memop), .ex_storedata(ex_storedata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwe(ex_mem_regwe), .ex_mem_wbdata(ex_mem_wbdata),
    .stallreq(stallreq), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } bus_t;
  typedef struct packed { logic [4:0] rd; logic [31:0] data; } wb_t;

  bus_t bus_q[$];
  wb_t  wb_q[$];
  int   mis_q[$];
  int   stall_q[$];

  logic [31:0] ref_mem [int];
  logic [31:0] slv_mem [int];

  int checks = 0;
  int errors = 0;

  bit resp_en = 1'b1;
  bit spurious_en = 1'b0;
  bit man_ack = 1'b0;
  int force_delay = -1;

  function automatic logic [31:0] init_word(input int widx);
    return (widx * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_rst(input string name);
    chk(name, {dmem_req, dmem_we, dmem_be, ex_mem_rd, ex_mem_regwe, misalign, stallreq}, 32'h0);
    chk({name, "_data"}, dmem_addr | dmem_wdata | ex_mem_wbdata, 32'h0);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (stallreq && guard < 50) begin @(negedge clk); guard++; end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL stall_timeout stallreq stuck high, expected release within 50 cycles");
    end
  endtask

  // Reference model: byte-addressed memory semantics at instruction level.
  task automatic model(input logic [3:0] op, input logic [4:0] rd, input logic regwe,
                       input logic [31:0] addr, input logic [31:0] sd);
    int size, pos, off, widx;
    bit is_load, sgn, mis;
    logic [31:0] w, data;
    logic [3:0] be;
    longint unsigned mask, v;
    if (op == 4'd0 || op > 4'd8) begin
      if (regwe) wb_q.push_back('{rd: rd, data: addr});
      return;
    end
    is_load = (op <= 4'd5);
    sgn     = (op == 4'd1 || op == 4'd2);
    size    = (op == 4'd1 || op == 4'd4 || op == 4'd6) ? 1 :
              (op == 4'd2 || op == 4'd5 || op == 4'd7) ? 2 : 4;
    off     = addr % 4;
`ifdef MEM_MISALIGN_CHECK_EN
    mis = (size == 2 && off % 2 != 0) || (size == 4 && off != 0);
`else
    mis = 1'b0;
`endif
    if (mis) begin mis_q.push_back(1); return; end
    widx = int'(addr / 4);
    if (!ref_mem.exists(widx)) ref_mem[widx] = init_word(widx);
    w   = ref_mem[widx];
    pos = (size == 1) ? off : (size == 2) ? (off / 2) * 2 : 0;
    if (is_load) begin
      bus_q.push_back('{we: 1'b0, addr: widx * 4, wdata: 32'h0, be: 4'hF});
      mask = (64'd1 << (8 * size)) - 1;
      v = ({32'h0, w} >> (8 * pos)) & mask;
      if (sgn && v > (mask >> 1)) v = v | ~mask;
      if (regwe && rd != 5'd0) wb_q.push_back('{rd: rd, data: v[31:0]});
    end else begin
      be = 4'h0;
      data = 32'h0;
      for (int i = 0; i < size; i++) be[pos + i] = 1'b1;
      for (int i = 0; i < 4; i++) data[8*i +: 8] = sd[8*(i % size) +: 8];
      for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = data[8*i +: 8];
      ref_mem[widx] = w;
      bus_q.push_back('{we: 1'b1, addr: widx * 4, wdata: data, be: be});
    end
  endtask

  // Call at a negedge. Presents junk with ex_valid=1 while stalled (must be
  // ignored), then the real instruction on the first idle cycle.
  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic regwe,
                       input logic [31:0] addr, input logic [31:0] sd, input bit use_model);
    int guard = 0;
    while (stallreq && guard < 50) begin
      ex_valid = 1'b1; ex_rd = 5'($urandom); ex_regwe = 1'b1;
      ex_result = $urandom; ex_memop = 4'($urandom); ex_storedata = $urandom;
      @(negedge clk); guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL issue_timeout stallreq stuck high, expected release within 50 cycles");
    end
    ex_valid = 1'b1; ex_rd = rd; ex_regwe = regwe; ex_result = addr;
    ex_memop = op; ex_storedata = sd;
    if (use_model) model(op, rd, regwe, addr, sd);
    @(negedge clk);
    ex_valid = 1'b0; ex_rd = 5'($urandom); ex_regwe = 1'b1;
    ex_result = $urandom; ex_memop = 4'($urandom); ex_storedata = $urandom;
  endtask

  // Data-bus responder with its own memory image.
  initial begin
    int d, widx;
    logic [31:0] w;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
      if (!resp_en) begin
        dmem_ack = man_ack;
      end else if (rst_n && dmem_req) begin
        d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
        stall_q.push_back(d + 1);
        repeat (d) @(negedge clk);
        widx = int'(dmem_addr >> 2);
        if (!slv_mem.exists(widx)) slv_mem[widx] = init_word(widx);
        w = slv_mem[widx];
        dmem_ack = 1'b1;
        dmem_rdata = w;
        if (dmem_we) begin
          for (int i = 0; i < 4; i++) if (dmem_be[i]) w[8*i +: 8] = dmem_wdata[8*i +: 8];
          slv_mem[widx] = w;
        end
      end else if (spurious_en && rst_n && $urandom_range(0, 7) == 0) begin
        dmem_ack = 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    bit prev_req = 1'b0;
    int stall_cnt = 0;
    bus_t b, snap;
    wb_t  e;
    snap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0;
        stall_cnt = 0;
      end else begin
        if (dmem_req && !prev_req) begin
          if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL bus_unexpected addr=%h we=%b, expected no request", dmem_addr, dmem_we);
          end else begin
            b = bus_q.pop_front();
            chk("bus_we", {31'h0, dmem_we}, {31'h0, b.we});
            chk("bus_addr", dmem_addr, b.addr);
            chk("bus_be", {28'h0, dmem_be}, {28'h0, b.be});
            if (b.we) chk("bus_wdata", dmem_wdata, b.wdata);
          end
          chk("bus_stall", {31'h0, stallreq}, 32'h1);
          snap = '{we: dmem_we, addr: dmem_addr, wdata: dmem_wdata, be: dmem_be};
        end else if (dmem_req) begin
          chk("bus_hold", {dmem_addr ^ dmem_wdata}, {snap.addr ^ snap.wdata});
          chk("bus_hold_ctl", {27'h0, dmem_we, dmem_be}, {27'h0, snap.we, snap.be});
        end
        prev_req = dmem_req;

        if (stallreq) stall_cnt++;
        else if (stall_cnt > 0) begin
          if (stall_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL stall_unexpected stalled %0d cycles, expected no stall", stall_cnt);
          end else chk("stall_len", stall_cnt, stall_q.pop_front());
          stall_cnt = 0;
        end

        if (ex_mem_regwe) begin
          if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected rd=%0d data=%h, expected no writeback", ex_mem_rd, ex_mem_wbdata);
          end else begin
            e = wb_q.pop_front();
            chk("wb_rd", {27'h0, ex_mem_rd}, {27'h0, e.rd});
            chk("wb_data", ex_mem_wbdata, e.data);
          end
        end

        if (misalign) begin
          checks++;
          if (mis_q.size() == 0) begin
            errors++;
            $display("FAIL misalign_unexpected actual=1 expected=0");
          end else void'(mis_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    ex_valid = 1'b0; ex_rd = 5'h0; ex_regwe = 1'b0; ex_result = 32'h0;
    ex_memop = 4'h0; ex_storedata = 32'h0;
    #1 rst_n = 1'b0;
    #1 check_rst("reset_init");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD-like passthrough
    wb_q.push_back('{rd: 5'd5, data: 32'h10});
    issue(4'd0, 5'd5, 1'b1, 32'h0000_0010, 32'h0, 1'b0);
    chk("add_stall", {31'h0, stallreq}, 32'h0);

    // LB 0x103, ack on third busy cycle
    slv_mem[32'h103 >> 2] = 32'h80FF_FF7F;
    force_delay = 2;
    bus_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF});
    wb_q.push_back('{rd: 5'd9, data: 32'hFFFF_FF80});
    issue(4'd1, 5'd9, 1'b1, 32'h103, 32'h0, 1'b0);
    @(negedge clk);
    chk("lb_stall_mid", {31'h0, stallreq}, 32'h1);

    // SH 0x22, ack first cycle
    force_delay = 0;
    bus_q.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'hABCD_ABCD, be: 4'b1100});
    issue(4'd7, 5'd3, 1'b1, 32'h22, 32'h1234_ABCD, 1'b0);

    // LBU 0x101
    wait_idle();
    force_delay = -1;
    slv_mem[32'h101 >> 2] = 32'h0000_9A00;
    bus_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, be: 4'hF});
    wb_q.push_back('{rd: 5'd12, data: 32'h0000_009A});
    issue(4'd4, 5'd12, 1'b1, 32'h101, 32'h0, 1'b0);

    // LW 0x202 (misaligned word)
    wait_idle();
    slv_mem[32'h202 >> 2] = 32'hCAFE_F00D;
`ifdef MEM_MISALIGN_CHECK_EN
    mis_q.push_back(1);
`else
    bus_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0, be: 4'hF});
    wb_q.push_back('{rd: 5'd14, data: 32'hCAFE_F00D});
`endif
    issue(4'd3, 5'd14, 1'b1, 32'h202, 32'h0, 1'b0);

    // Load to x0, reserved opcode passthrough
    issue(4'd3, 5'd0, 1'b1, 32'h410, 32'h0, 1'b1);
    issue(4'd12, 5'd6, 1'b1, 32'h1234_5678, 32'h0, 1'b1);

    // Reset in the middle of a busy access, late ack afterwards
    wait_idle();
    resp_en = 1'b0;
    bus_q.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, be: 4'hF});
    issue(4'd3, 5'd7, 1'b1, 32'h300, 32'h0, 1'b0);
    @(negedge clk);
    chk("rst_busy_pre", {31'h0, stallreq}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_rst("reset_mid_busy");
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1 man_ack = 1'b1;
    @(negedge clk);
    #1 man_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_after_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_after_stall", {31'h0, stallreq}, 32'h0);
    chk("rst_after_regwe", {31'h0, ex_mem_regwe}, 32'h0);
    resp_en = 1'b1;

    // Randomized traffic against the reference model
    spurious_en = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] op;
      logic [31:0] a;
      op = 4'($urandom_range(0, 15));
      a = (op >= 4'd1 && op <= 4'd8) ? 32'h400 + $urandom_range(0, 255) : $urandom;
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      else issue(op, 5'($urandom_range(0, 31)), ($urandom_range(0, 4) != 0), a, $urandom, 1'b1);
    end
    spurious_en = 1'b0;

    wait_idle();
    repeat (4) @(negedge clk);
    chk("drain_bus", bus_q.size(), 0);
    chk("drain_wb", wb_q.size(), 0);
    chk("drain_mis", mis_q.size(), 0);
    chk("drain_stall", stall_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
